// File: rtl/fir_frame_ctrl.sv
// Frame sequencer for a free-running FIR: buffers one frame, clears the filter,
// streams the frame plus NUM_TAPS-1 flush zeros, and tags the output with valid/last.
//
//   state | meaning
//   IDLE  | accept samples into the buffer until in_last or buffer full
//   CLEAR | fir_clr high for one cycle, fir_x = 0
//   FEED  | fir_x = buffered sample, one per cycle, n cycles
//   FLUSH | fir_x = 0 for NUM_TAPS-1 cycles to drain the delay line
//   DRAIN | fir_x = 0, wait FIR_LAT cycles for the tag pipeline to empty
module fir_frame_ctrl #(
   parameter int DATA_W    = 16,
   parameter int ACC_W     = 32,
   parameter int FRAME_LEN = 20,
   parameter int NUM_TAPS  = 4,
   parameter int FIR_LAT   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_last,
   output logic signed [DATA_W-1:0] fir_x,
   output logic                     fir_clr,
   input  logic signed [ACC_W-1:0]  fir_y,
   output logic                     out_valid,
   output logic signed [ACC_W-1:0]  out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int PTR_W   = $clog2(FRAME_LEN + 1);
   localparam int TMR_MAX = (NUM_TAPS > FIR_LAT) ? NUM_TAPS : FIR_LAT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [PTR_W-1:0] FULL     = PTR_W'(FRAME_LEN);
   localparam logic [TMR_W-1:0] FLUSH_TC = TMR_W'((NUM_TAPS > 1) ? NUM_TAPS - 2 : 0);
   localparam logic [TMR_W-1:0] DRAIN_TC = TMR_W'(FIR_LAT - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN} state_t;

   state_t                   state, state_nxt;
   logic [PTR_W-1:0]         count, count_nxt;
   logic [PTR_W-1:0]         rd_ptr, rd_ptr_nxt;
   logic [TMR_W-1:0]         tmr, tmr_nxt;
   logic signed [DATA_W-1:0] mem [FRAME_LEN];
   logic signed [DATA_W-1:0] fir_x_nxt;
   logic                     fir_clr_nxt;
   logic                     in_ready_nxt;
   logic                     done_nxt;
   logic                     accept;
   logic                     feed_end;
   logic                     vld_in;
   logic                     lst_in;
   logic [FIR_LAT-1:0]       vld_pipe;
   logic [FIR_LAT-1:0]       lst_pipe;

   // in_ready is only ever high while IDLE, so accept implies IDLE
   assign accept   = in_valid && in_ready;
   assign feed_end = (rd_ptr == count);

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      rd_ptr_nxt = rd_ptr;
      tmr_nxt    = tmr;
      fir_x_nxt  = '0;
      done_nxt   = 1'b0;
      vld_in     = 1'b0;
      lst_in     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               count_nxt = count + 1'b1;
               if (in_last || (count == FULL - 1'b1)) state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            state_nxt  = FEED;
            fir_x_nxt  = mem[rd_ptr];
            rd_ptr_nxt = rd_ptr + 1'b1;
         end
         FEED: begin
            vld_in = 1'b1;
            if (feed_end) begin
               if (NUM_TAPS == 1) begin
                  lst_in    = 1'b1;
                  state_nxt = DRAIN;
                  tmr_nxt   = DRAIN_TC;
               end else begin
                  state_nxt = FLUSH;
                  tmr_nxt   = FLUSH_TC;
               end
            end else begin
               fir_x_nxt  = mem[rd_ptr];
               rd_ptr_nxt = rd_ptr + 1'b1;
            end
         end
         FLUSH: begin
            vld_in = 1'b1;
            if (tmr == '0) begin
               lst_in    = 1'b1;
               state_nxt = DRAIN;
               tmr_nxt   = DRAIN_TC;
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
         end
         DRAIN: begin
            if (tmr == '0) begin
               state_nxt  = IDLE;
               count_nxt  = '0;
               rd_ptr_nxt = '0;
               done_nxt   = 1'b1;
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      fir_clr_nxt  = (state_nxt == CLEAR);
      // staying low through the frame_done cycle opens the next frame one cycle later
      in_ready_nxt = (state == IDLE) && (state_nxt == IDLE) && (count_nxt < FULL);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         count      <= '0;
         rd_ptr     <= '0;
         tmr        <= '0;
         fir_x      <= '0;
         fir_clr    <= 1'b1;
         in_ready   <= 1'b0;
         frame_done <= 1'b0;
         vld_pipe   <= '0;
         lst_pipe   <= '0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         rd_ptr     <= rd_ptr_nxt;
         tmr        <= tmr_nxt;
         fir_x      <= fir_x_nxt;
         fir_clr    <= fir_clr_nxt;
         in_ready   <= in_ready_nxt;
         frame_done <= done_nxt;
         vld_pipe   <= (vld_pipe << 1) | FIR_LAT'(vld_in);
         lst_pipe   <= (lst_pipe << 1) | FIR_LAT'(lst_in);
      end
   end

   // count doubles as the write pointer
   always_ff @(posedge clk) begin
      if (accept) mem[count] <= in_data;
   end

   assign busy      = (state != IDLE);
   assign out_valid = vld_pipe[FIR_LAT-1];
   assign out_last  = lst_pipe[FIR_LAT-1];
   assign out_data  = fir_y;

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Directed bench for fir_frame_ctrl with a 4-tap all-ones FIR stub (one clock latency).
module tb_fir_frame_ctrl;

   logic               clk;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in_data;
   logic               in_last;
   logic signed [15:0] fir_x;
   logic               fir_clr;
   logic signed [31:0] fir_y;
   logic               out_valid;
   logic signed [31:0] out_data;
   logic               out_last;
   logic               busy;
   logic               frame_done;

   fir_frame_ctrl #(
      .DATA_W(16), .ACC_W(32), .FRAME_LEN(20), .NUM_TAPS(4), .FIR_LAT(1)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .fir_x(fir_x), .fir_clr(fir_clr), .fir_y(fir_y),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .busy(busy), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural FIR, h = {1,1,1,1}, synchronous clear
   logic signed [31:0] d0, d1, d2, d3;
   always @(posedge clk) begin
      if (fir_clr) begin
         d0 <= 0; d1 <= 0; d2 <= 0; d3 <= 0;
      end else begin
         d0 <= {{16{fir_x[15]}}, fir_x};
         d1 <= d0; d2 <= d1; d3 <= d2;
      end
   end
   assign fir_y = d0 + d1 + d2 + d3;

   int total = 0;
   int bad   = 0;

   logic signed [31:0] oq[$];
   logic               lq[$];
   logic signed [15:0] xq[$];
   int  clr_cnt, vrise, fd_cnt;
   bit  seen99, rdy_busy, fd_after_last, fd_busy, prev_valid, prev_last;

   always @(negedge clk) begin
      if (reset) begin
         if (out_valid) begin
            oq.push_back(out_data);
            lq.push_back(out_last);
         end
         if (fir_clr && busy) clr_cnt++;
         if (busy && !fir_clr) xq.push_back(fir_x);
         if (fir_x == 16'sd99) seen99 = 1'b1;
         if (busy && in_ready) rdy_busy = 1'b1;
         if (out_valid && !prev_valid) vrise++;
         if (frame_done) begin
            fd_cnt++;
            fd_after_last = prev_last;
            fd_busy       = busy;
         end
         prev_valid = out_valid;
         prev_last  = out_valid && out_last;
      end
   end

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      oq.delete(); lq.delete(); xq.delete();
      clr_cnt = 0; vrise = 0; seen99 = 0; rdy_busy = 0;
      fd_after_last = 0; fd_busy = 1;
   endtask

   task automatic send(input int d, input bit l);
      int t;
      in_data  = 16'(d);
      in_last  = l;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("send_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_frame(input int n);
      int t;
      t = 0;
      while (fd_cnt < n && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("frame_done_seen", fd_cnt, n);
   endtask

   function automatic int last_count();
      int c = 0;
      foreach (lq[i]) if (lq[i]) c++;
      return c;
   endfunction

   int s2[20] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, -1, -2, -3, -4, -5, -6, -5, -4};
   int e1[6]  = '{1, 3, 6, 6, 5, 3};
   int e3[7]  = '{1, 3, 6, 10, 9, 7, 4};

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      fd_cnt = 0; prev_valid = 0; prev_last = 0;
      clr_mon();
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_fir_clr", fir_clr, 1);
      chk("rst_fir_x", fir_x, 0);
      reset = 1'b1;
      #1 chk("first_cycle_in_ready", in_ready, 0);
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);

      // 1: short frame
      clr_mon();
      send(1, 0); send(2, 0); send(3, 1);
      chk("t1_ready_drop", in_ready, 0);
      wait_frame(1);
      chk("t1_len", oq.size(), 6);
      for (int i = 0; i < 6; i++) chk($sformatf("t1_out%0d", i), oq[i], e1[i]);
      chk("t1_last_pos", lq[5], 1);
      chk("t1_last_cnt", last_count(), 1);
      chk("t1_clr_cycles", clr_cnt, 1);
      chk("t1_done_after_last", fd_after_last, 1);
      chk("t1_contig", vrise, 1);

      // 2: full frame, auto-close at 20
      clr_mon();
      for (int i = 0; i < 20; i++) send(s2[i], 0);
      chk("t2_ready_drop", in_ready, 0);
      chk("t2_busy", busy, 1);
      wait_frame(2);
      chk("t2_len", oq.size(), 23);
      for (int k = 0; k < 23; k++) begin
         e = 0;
         for (int j = 0; j < 4; j++) if (k - j >= 0 && k - j < 20) e += s2[k-j];
         chk($sformatf("t2_out%0d", k), oq[k], e);
      end
      chk("t2_first6", oq[5], 18);
      chk("t2_tail", oq[20], -15);
      chk("t2_final", oq[22], -4);
      chk("t2_last_pos", lq[22], 1);
      chk("t2_last_cnt", last_count(), 1);
      chk("t2_contig", vrise, 1);

      // 3+4: gapped input, then in_valid held with 99 while busy
      clr_mon();
      send(1, 0); @(negedge clk);
      send(2, 0); @(negedge clk);
      send(3, 0); @(negedge clk);
      send(4, 1);
      in_valid = 1'b1; in_data = 16'sd99; in_last = 1'b0;
      wait_frame(3);
      in_valid = 1'b0;
      chk("t3_len", oq.size(), 7);
      for (int i = 0; i < 7; i++) chk($sformatf("t3_out%0d", i), oq[i], e3[i]);
      for (int i = 0; i < 4; i++) chk($sformatf("t3_fir_x%0d", i), xq[i], i + 1);
      chk("t3_fir_x_flush", xq[4], 0);
      chk("t3_last_pos", lq[6], 1);
      chk("t4_ready_while_busy", rdy_busy, 0);
      chk("t4_no99", seen99, 0);

      // 6: single sample frame right after
      clr_mon();
      send(5, 1);
      wait_frame(4);
      chk("t6_len", oq.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t6_out%0d", i), oq[i], 5);
      chk("t6_last3", lq[3], 1);
      chk("t6_last2", lq[2], 0);
      chk("t6_busy_at_done", fd_busy, 0);
      chk("t6_no99", seen99, 0);

      // 5: reset on the 2nd FEED cycle
      clr_mon();
      send(1, 0); send(2, 0); send(3, 1);
      begin
         int t = 0;
         while (!fir_clr && t < 50) begin
            @(negedge clk);
            t++;
         end
      end
      chk("t5_clear_seen", fir_clr, 1);
      @(negedge clk);
      @(negedge clk);
      chk("t5_pre_valid", out_valid, 1);
      #2 reset = 1'b0;
      #1;
      chk("t5_out_valid", out_valid, 0);
      chk("t5_fir_clr", fir_clr, 1);
      chk("t5_busy", busy, 0);
      chk("t5_out_last", out_last, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      chk("t5_no_done", fd_cnt, 4);
      clr_mon();
      send(7, 1);
      wait_frame(5);
      chk("t5_len", oq.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t5_out%0d", i), oq[i], 7);
      chk("t5_last_pos", lq[3], 1);
      chk("t5_last_cnt", last_count(), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
